// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer for the shared RAM.
// One transaction at a time: IDLE -> ISSUE -> (WAIT -> RESP) -> IDLE.
module mem_arbiter #(
  parameter int AW         = 9,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic [1:0]    m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_write,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          own_q, own_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;

  logic act0, act1, win, last;

  assign act0 = (m0_cmd == 2'b01) || (m0_cmd == 2'b10);
  assign act1 = (m1_cmd == 2'b01) || (m1_cmd == 2'b10);
  assign last = (cnt_q == 3'd1);

  // Winner: m1 only when it is alone or it is favoured in round-robin.
  always_comb begin
    win = 1'b0;
    if (act1) begin
      if (!act0) win = 1'b1;
      else if (FIXED_PRIO == 0) win = rr_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (act0 || act1) state_d = S_ISSUE;
      S_ISSUE: state_d = wr_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (last) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state and latched command.
  always_comb begin
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_write = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        ram_addr = addr_q;
        if (wr_q) begin
          ram_write = 1'b1;
          ram_wdata = wdata_q;
          m0_ack    = ~own_q;
          m1_ack    = own_q;
        end
      end
      S_WAIT: ram_addr = addr_q;
      S_RESP: begin
        m0_ack = ~own_q;
        m1_ack = own_q;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign owner    = own_q;
  assign m0_rdata = rd0_q;
  assign m1_rdata = rd1_q;

  // Datapath next values: grant latch, wait counter, read capture.
  always_comb begin
    rr_d    = rr_q;
    own_d   = own_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    unique case (state_q)
      S_IDLE: begin
        if (act0 || act1) begin
          own_d   = win;
          wr_d    = win ? m1_cmd[1] : m0_cmd[1];
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          if (FIXED_PRIO == 0) rr_d = ~win;
        end
      end
      S_ISSUE: cnt_d = 3'(RD_LAT);
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (last) begin
          if (own_q) rd1_d = ram_rdata;
          else       rd0_d = ram_rdata;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q    <= 1'b0;
      own_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter.
// DUT a: RD_LAT=1 round-robin; DUT b: RD_LAT=3 fixed priority.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  cmd   [4];
  logic [8:0]  addr  [4];
  logic [15:0] wd    [4];
  logic [3:0]  ack;
  logic [15:0] rd    [4];
  logic [8:0]  ram_addr  [2];
  logic [15:0] ram_wdata [2];
  logic [15:0] ram_rdata [2];
  logic [1:0]  ram_write;
  logic [1:0]  busy;
  logic [1:0]  owner;

  mem_arbiter #(.RD_LAT(1), .FIXED_PRIO(0)) u_a (
    .clk(clk), .reset(rst_n),
    .m0_cmd(cmd[0]), .m0_addr(addr[0]), .m0_wdata(wd[0]),
    .m0_ack(ack[0]), .m0_rdata(rd[0]),
    .m1_cmd(cmd[1]), .m1_addr(addr[1]), .m1_wdata(wd[1]),
    .m1_ack(ack[1]), .m1_rdata(rd[1]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_write(ram_write[0]), .ram_rdata(ram_rdata[0]),
    .busy(busy[0]), .owner(owner[0])
  );

  mem_arbiter #(.RD_LAT(3), .FIXED_PRIO(1)) u_b (
    .clk(clk), .reset(rst_n),
    .m0_cmd(cmd[2]), .m0_addr(addr[2]), .m0_wdata(wd[2]),
    .m0_ack(ack[2]), .m0_rdata(rd[2]),
    .m1_cmd(cmd[3]), .m1_addr(addr[3]), .m1_wdata(wd[3]),
    .m1_ack(ack[3]), .m1_rdata(rd[3]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_write(ram_write[1]), .ram_rdata(ram_rdata[1]),
    .busy(busy[1]), .owner(owner[1])
  );

  // RAM models: 1-cycle and 3-cycle read latency.
  logic [15:0] mem_a [512];
  logic [15:0] mem_b [512];
  logic [15:0] pa;
  logic [15:0] pb [3];

  always @(posedge clk) begin
    if (ram_write[0]) mem_a[ram_addr[0]] <= ram_wdata[0];
    pa <= mem_a[ram_addr[0]];
  end

  always @(posedge clk) begin
    if (ram_write[1]) mem_b[ram_addr[1]] <= ram_wdata[1];
    pb[0] <= mem_b[ram_addr[1]];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end

  assign ram_rdata[0] = pa;
  assign ram_rdata[1] = pb[2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Single write from requester p, started in IDLE.
  task automatic wr(int p, logic [8:0] a, logic [15:0] d);
    int u;
    u = p / 2;
    cmd[p] = 2'b10; addr[p] = a; wd[p] = d;
    step;
    chk("wr_ack", 32'(ack[p]), 1);
    chk("wr_en", 32'(ram_write[u]), 1);
    chk("wr_addr", 32'(ram_addr[u]), 32'(a));
    chk("wr_data", 32'(ram_wdata[u]), 32'(d));
    chk("wr_owner", 32'(owner[u]), 32'(p % 2));
    cmd[p] = 2'b00;
    step;
    chk("wr_done_ack", 32'(ack[p]), 0);
    chk("wr_done_busy", 32'(busy[u]), 0);
  endtask

  // Single read from requester p; lat is cycles from T to ack.
  task automatic rd_chk(int p, logic [8:0] a, logic [15:0] e, int lat);
    int n;
    bit got;
    n = 0; got = 1'b0;
    cmd[p] = 2'b01; addr[p] = a;
    while (n < 12 && !got) begin
      step;
      n++;
      if (ack[p]) got = 1'b1;
    end
    chk("rd_lat", 32'(n), 32'(lat));
    chk("rd_data", 32'(rd[p]), 32'(e));
    cmd[p] = 2'b00;
    step;
    chk("rd_done_ack", 32'(ack[p]), 0);
    chk("rd_done_busy", 32'(busy[p / 2]), 0);
  endtask

  initial begin
    logic [1:0] e2;
    for (int i = 0; i < 4; i++) begin
      cmd[i] = 2'b00; addr[i] = '0; wd[i] = '0;
    end
    rst_n = 1'b0;
    cmd[0] = 2'b10; addr[0] = 9'h005; wd[0] = 16'hBEEF;
    repeat (3) step;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_wen", 32'(ram_write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_rdata", 32'(rd[0]), 0);
    chk("rst_raddr", 32'(ram_addr[0]), 0);

    // Release with the write pending: ack at T+1.
    rst_n = 1'b1;
    chk("t0_busy", 32'(busy[0]), 0);
    step;
    chk("t1_ack", 32'(ack[0]), 1);
    chk("t1_wen", 32'(ram_write[0]), 1);
    chk("t1_addr", 32'(ram_addr[0]), 32'h5);
    chk("t1_data", 32'(ram_wdata[0]), 32'hBEEF);
    cmd[0] = 2'b00;
    step;
    chk("t2_ack", 32'(ack[0]), 0);
    chk("t2_busy", 32'(busy[0]), 0);

    rd_chk(0, 9'h005, 16'hBEEF, 3);
    wr(0, 9'h010, 16'h1111);
    wr(1, 9'h020, 16'h2222);
    wr(1, 9'h1FF, 16'hA5A5);
    rd_chk(1, 9'h020, 16'h2222, 3);

    wr(2, 9'h005, 16'hBEEF);
    rd_chk(2, 9'h005, 16'hBEEF, 5);
    wr(3, 9'h007, 16'h7777);
    rd_chk(3, 9'h007, 16'h7777, 5);

    // Round-robin contention from reset.
    rst_n = 1'b0;
    step;
    cmd[0] = 2'b01; addr[0] = 9'h010;
    cmd[1] = 2'b01; addr[1] = 9'h020;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e2 = 2'b00;
      if (i == 3 || i == 11) e2 = 2'b01;
      if (i == 7 || i == 15) e2 = 2'b10;
      chk("rr_ack", 32'(ack[1:0]), 32'(e2));
      if (i % 4 == 1) chk("rr_owner", 32'(owner[0]), 32'((i / 4) % 2));
      if (i == 3) chk("rr_rd0", 32'(rd[0]), 32'h1111);
      if (i == 7) chk("rr_rd1", 32'(rd[1]), 32'h2222);
      step;
    end
    cmd[0] = 2'b00; cmd[1] = 2'b00;
    step;
    chk("rr_idle", 32'(busy[0]), 0);

    // Fixed priority: m0 wins until it withdraws.
    cmd[2] = 2'b01; addr[2] = 9'h005;
    cmd[3] = 2'b01; addr[3] = 9'h007;
    for (int i = 0; i < 24; i++) begin
      if (i == 18) cmd[2] = 2'b00;
      e2 = 2'b00;
      if (i == 5 || i == 11 || i == 17) e2 = 2'b01;
      if (i == 23) e2 = 2'b10;
      chk("fp_ack", 32'(ack[3:2]), 32'(e2));
      if (i == 23) begin
        chk("fp_rd1", 32'(rd[3]), 32'h7777);
        chk("fp_owner", 32'(owner[1]), 1);
      end
      step;
    end
    cmd[3] = 2'b00;
    step;
    chk("fp_idle", 32'(busy[1]), 0);

    // Illegal command 11.
    cmd[1] = 2'b11;
    repeat (3) begin
      step;
      chk("ill_ack", 32'(ack[1]), 0);
      chk("ill_busy", 32'(busy[0]), 0);
    end
    cmd[1] = 2'b00;

    // Read withdrawn during ISSUE still completes.
    cmd[0] = 2'b01; addr[0] = 9'h1FF;
    step;
    chk("wd_addr", 32'(ram_addr[0]), 32'h1FF);
    cmd[0] = 2'b00; addr[0] = 9'h000;
    step;
    chk("wd_hold", 32'(ram_addr[0]), 32'h1FF);
    step;
    chk("wd_ack", 32'(ack[0]), 1);
    chk("wd_data", 32'(rd[0]), 32'hA5A5);
    chk("wd_rd1_hold", 32'(rd[1]), 32'h2222);
    step;
    chk("wd_done", 32'(ack[0]), 0);

    // Reset while waiting on a read.
    cmd[0] = 2'b01; addr[0] = 9'h005;
    step;
    step;
    chk("mr_busy_pre", 32'(busy[0]), 1);
    rst_n = 1'b0;
    cmd[0] = 2'b00;
    #1;
    chk("mr_busy", 32'(busy[0]), 0);
    chk("mr_ack", 32'(ack[0]), 0);
    chk("mr_rd0", 32'(rd[0]), 0);
    chk("mr_rd1", 32'(rd[1]), 0);
    chk("mr_addr", 32'(ram_addr[0]), 0);
    step;
    rst_n = 1'b1;
    step;
    rd_chk(0, 9'h005, 16'hBEEF, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
